wr_fifo_pack: RTL and testbench

WR_FIFO_PACK -- requirements
Module: wr_fifo_pack

---
 rtl/wr_fifo_pack.sv | 144 ++++++++++++++
 tb/tb_wr_fifo_pack.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wr_fifo_pack.sv
// wr_fifo_pack
//   Packs 32-bit pixel beats into 128-bit words and buffers them in a small
//   first-word-fall-through FIFO that feeds a DDR write master.
//
//   Build option: define WR_FIFO_PACK_FLUSH_EN to enable in_flush.
//   When enabled, in_flush commits a partially filled word with its
//   unfilled upper lanes zeroed. If storage is full, the commit waits in
//   flush_pend until a slot frees up. When the macro is not defined,
//   in_flush is ignored.
//
// Ports
//   clk        : single clock
//   rst        : asynchronous, active-high reset
//   in_en      : a 32-bit beat is presented on in_data
//   in_data    : beat data (the first beat of a word lands in bits [31:0])
//   in_rdy     : a beat is accepted this cycle when in_en is also high
//   in_flush   : single-cycle pulse that forces commit of a partial word
//   out_rd_en  : the consumer takes the head word
//   out_vld    : the head word is valid (word_cnt != 0)
//   out_data   : the head word, or 0 when the FIFO is empty
//   burst_rdy  : word_cnt >= BURST_LEN
//   word_cnt   : number of stored 128-bit words
//   ovf        : sticky; set when a beat was dropped, cleared only by reset
module wr_fifo_pack #(
  parameter int DEPTH_WIDTH = 4,
  parameter int BURST_LEN   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_en,
  input  logic [31:0]            in_data,
  output logic                   in_rdy,
  input  logic                   in_flush,
  input  logic                   out_rd_en,
  output logic                   out_vld,
  output logic [127:0]           out_data,
  output logic                   burst_rdy,
  output logic [DEPTH_WIDTH:0]   word_cnt,
  output logic                   ovf
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0]   FULL_CNT  = (DEPTH_WIDTH+1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0]   BURST_CNT = (DEPTH_WIDTH+1)'(BURST_LEN);
  localparam logic [DEPTH_WIDTH:0]   CNT_ONE   = (DEPTH_WIDTH+1)'(1);
  localparam logic [DEPTH_WIDTH-1:0] PTR_ONE   = DEPTH_WIDTH'(1);

  logic [127:0]           mem_q [DEPTH];
  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_WIDTH:0]   cnt_q, cnt_d;
  logic [1:0]             lane_q, lane_d, lane_after;
  logic [95:0]            pack_q, pack_d;
  logic                   flush_pend_q, flush_pend_d;
  logic                   ovf_q, ovf_d;
  logic                   full, accept, rd, commit, commit_wr;
  logic [127:0]           merged;

`ifndef WR_FIFO_PACK_FLUSH_EN
  logic unused_flush;
  assign unused_flush = in_flush;
`endif

  always_comb begin
    full   = (cnt_q == FULL_CNT);
    in_rdy = !full && !flush_pend_q;
    accept = in_en && in_rdy;
    rd     = out_rd_en && out_vld;

    // Lanes above the current one are always zero in pack_q, because pack_q
    // is cleared on every commit. That zero padding is what a flushed word needs.
    merged = {32'b0, pack_q};
    for (int i = 0; i < 4; i++) begin
      if (accept && lane_q == 2'(i)) merged[i*32 +: 32] = in_data;
    end
    lane_after = accept ? lane_q + 2'd1 : lane_q;

    commit       = 1'b0;
    pack_d       = accept ? merged[95:0] : pack_q;
    lane_d       = lane_after;
    flush_pend_d = flush_pend_q;
    ovf_d        = ovf_q | (in_en && !in_rdy);

    if (accept && lane_q == 2'd3) begin
      commit = 1'b1;
`ifdef WR_FIFO_PACK_FLUSH_EN
    end else if ((in_flush || flush_pend_q) && lane_after != 2'd0) begin
      // A flush cannot take effect while storage is full; it is held pending.
      if (!full) begin
        commit       = 1'b1;
        flush_pend_d = 1'b0;
      end else begin
        flush_pend_d = 1'b1;
      end
`endif
    end

    if (commit) begin
      pack_d = '0;
      lane_d = 2'd0;
    end

    wr_ptr_d = commit ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    case ({commit, rd})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // The reset edge must never write storage.
  assign commit_wr = commit && !rst;

  always_ff @(posedge clk) begin
    if (commit_wr) mem_q[wr_ptr_q] <= merged;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      lane_q       <= 2'd0;
      pack_q       <= '0;
      flush_pend_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      flush_pend_q <= flush_pend_d;
      ovf_q        <= ovf_d;
    end
  end

  assign out_vld   = (cnt_q != '0);
  assign out_data  = out_vld ? mem_q[rd_ptr_q] : 128'b0;
  assign burst_rdy = (cnt_q >= BURST_CNT);
  assign word_cnt  = cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_wr_fifo_pack.sv
module tb_wr_fifo_pack;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_en, in_flush, out_rd_en;
  logic [31:0]  in_data;
  logic         in_rdy, out_vld, burst_rdy, ovf;
  logic [127:0] out_data;
  logic [4:0]   word_cnt;

  int n_vec = 0;
  int n_err = 0;

  wr_fifo_pack dut (
    .clk(clk), .rst(rst),
    .in_en(in_en), .in_data(in_data), .in_rdy(in_rdy), .in_flush(in_flush),
    .out_rd_en(out_rd_en), .out_vld(out_vld), .out_data(out_data),
    .burst_rdy(burst_rdy), .word_cnt(word_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of stored words, a queue of pending beats.
  logic [127:0] mq[$];
  logic [31:0]  part[$];
  logic         m_ovf, m_pend;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    part.delete();
    m_ovf  = 1'b0;
    m_pend = 1'b0;
  endtask

  task automatic check_model();
    int sz;
    sz = mq.size();
    chk("in_rdy",    in_rdy,    (sz != 16) && !m_pend);
    chk("out_vld",   out_vld,   sz != 0);
    chk("out_data",  out_data,  (sz != 0) ? mq[0] : 128'b0);
    chk("word_cnt",  word_cnt,  sz);
    chk("burst_rdy", burst_rdy, sz >= 8);
    chk("ovf",       ovf,       m_ovf);
  endtask

  task automatic model_step(input logic en, input logic [31:0] d, input logic fl, input logic rd);
    logic full, rdy, commit;
    logic [127:0] word;
    full   = (mq.size() == 16);
    rdy    = !full && !m_pend;
    commit = 1'b0;
    word   = '0;
    if (en && rdy) part.push_back(d);
    else if (en) m_ovf = 1'b1;
    if (part.size() == 4) commit = 1'b1;
`ifdef WR_FIFO_PACK_FLUSH_EN
    else if ((fl || m_pend) && part.size() != 0) begin
      if (!full) commit = 1'b1;
      else m_pend = 1'b1;
    end
`endif
    if (commit) begin
      for (int i = 0; i < part.size(); i++) word[i*32 +: 32] = part[i];
      part.delete();
      m_pend = 1'b0;
    end
    if (rd && mq.size() != 0) void'(mq.pop_front());
    if (commit) mq.push_back(word);
  endtask

  // One clock: drive on negedge, compare pre-edge outputs, advance model,
  // return 1 time unit after the edge so callers can check new state.
  task automatic cycle(input logic en, input logic [31:0] d, input logic fl, input logic rd);
    @(negedge clk);
    in_en = en; in_data = d; in_flush = fl; out_rd_en = rd;
    #1;
    check_model();
    @(posedge clk);
    model_step(en, d, fl, rd);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_en = 1'b0; in_data = '0; in_flush = 1'b0; out_rd_en = 1'b0;
    #1;
    model_clear();
    check_model();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic         en;
    logic [31:0]  d;
    logic         fl;
    logic         rd;
    logic         e_rdy;
    logic         e_vld;
    logic [4:0]   e_cnt;
    logic [127:0] e_data;
  } vec_t;

  vec_t tbl[7];
  localparam logic [127:0] W1 = 128'h44444444_33333333_22222222_11111111;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int pe, pr;

    tbl[0] = '{1'b1, 32'h11111111, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 128'h0};
    tbl[1] = '{1'b1, 32'h22222222, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 128'h0};
    tbl[2] = '{1'b1, 32'h33333333, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 128'h0};
    tbl[3] = '{1'b1, 32'h44444444, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 128'h0};
    tbl[4] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 5'd1, W1};
    tbl[5] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 5'd1, W1};
    tbl[6] = '{1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 128'h0};

    rst = 1'b1;
    in_en = 1'b0; in_data = '0; in_flush = 1'b0; out_rd_en = 1'b0;
    model_clear();
    #1;
    check_model();
    do_reset();

    // Directed first word, table driven.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      in_en = tbl[i].en; in_data = tbl[i].d; in_flush = tbl[i].fl; out_rd_en = tbl[i].rd;
      #1;
      chk("tbl_rdy",  in_rdy,   tbl[i].e_rdy);
      chk("tbl_vld",  out_vld,  tbl[i].e_vld);
      chk("tbl_cnt",  word_cnt, tbl[i].e_cnt);
      chk("tbl_data", out_data, tbl[i].e_data);
      @(posedge clk);
      model_step(tbl[i].en, tbl[i].d, tbl[i].fl, tbl[i].rd);
      #1;
    end

    // burst_rdy threshold, then fill to full and overflow.
    do_reset();
    v = 32'h1000_0000;
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, v, 1'b0, 1'b0); v++;
      if (i == 27) begin
        chk("burst_pre", burst_rdy, 1'b0);
        chk("cnt7", word_cnt, 5'd7);
      end
    end
    chk("burst8", burst_rdy, 1'b1);
    chk("cnt8", word_cnt, 5'd8);
    for (int i = 0; i < 32; i++) begin
      cycle(1'b1, v, 1'b0, 1'b0); v++;
    end
    chk("cnt_full", word_cnt, 5'd16);
    chk("rdy_full", in_rdy, 1'b0);
    chk("ovf_pre", ovf, 1'b0);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("ovf_set", ovf, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("rdy_after_rd", in_rdy, 1'b1);
    chk("cnt_after_rd", word_cnt, 5'd15);

    // Reset mid-word with stored words.
    for (int i = 0; i < 12; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    cycle(1'b1, 32'hAAAA_0002, 1'b0, 1'b0);
    chk("cnt3_prerst", word_cnt, 5'd3);
    do_reset();
    chk("rst_vld", out_vld, 1'b0);
    chk("rst_cnt", word_cnt, 5'd0);
    chk("rst_ovf", ovf, 1'b0);
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'hC0DE_0000 + 32'(i), 1'b0, 1'b0);
    chk("clean_cnt", word_cnt, 5'd1);
    chk("clean_word", out_data, 128'hC0DE0004_C0DE0003_C0DE0002_C0DE0001);

    // Commit and read in the same cycle at word_cnt=3, then wrap.
    for (int i = 0; i < 11; i++) begin
      cycle(1'b1, v, 1'b0, 1'b0); v++;
    end
    chk("cnt3", word_cnt, 5'd3);
    cycle(1'b1, v, 1'b0, 1'b1); v++;
    chk("cnt3_rw", word_cnt, 5'd3);
    for (int i = 0; i < 80; i++) begin
      cycle(1'b1, v, 1'b0, mq.size() > 1); v++;
    end

    // Flush handling.
    do_reset();
`ifdef WR_FIFO_PACK_FLUSH_EN
    cycle(1'b1, 32'hA, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush_cnt", word_cnt, 5'd1);
    chk("flush_word", out_data, 128'h00000000_00000000_0000000B_0000000A);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush_noop", word_cnt, 5'd1);
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
    chk("flush_lane0", word_cnt, 5'd2);
`else
    cycle(1'b1, 32'hA, 1'b0, 1'b0);
    cycle(1'b1, 32'hB, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("noflush_cnt", word_cnt, 5'd0);
    cycle(1'b1, 32'hC, 1'b0, 1'b0);
    cycle(1'b1, 32'hD, 1'b0, 1'b0);
    chk("noflush_word", out_data, 128'h0000000D_0000000C_0000000B_0000000A);
`endif

    // Randomized traffic in phases that push toward full and toward empty.
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0:       begin pe = 90; pr = 20; end
        1:       begin pe = 30; pr = 90; end
        2:       begin pe = 70; pr = 65; end
        default: begin pe = 97; pr = 5;  end
      endcase
      for (int i = 0; i < 500; i++) begin
        cycle($urandom_range(99) < pe, $urandom, $urandom_range(99) < 4,
              $urandom_range(99) < pr);
      end
    end
    for (int i = 0; i < 40; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
